// File: rtl/hex_io_arbiter.sv
// Round-robin two-master IO write arbiter with hex-window decode; HEX_IO_ARB_LOCK_EN adds i_lock bursts.
// Latency: request seen in IDLE -> grant/ack/bus write next cycle, then HOLD_CYCLES idle gap.
// Backpressure: masters hold req/we/addr/data until o_ack; requests are sampled only in IDLE.
module hex_io_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  WINDOW_BASE = 8'h80,
    parameter int unsigned WINDOW_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  i_req,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [7:0]  i_addr0,
    input  logic [7:0]  i_addr1,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
`ifdef HEX_IO_ARB_LOCK_EN
    input  logic [1:0]  i_lock,
`endif
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_ack,
    output logic        o_IO_we,
    output logic [7:0]  o_IO_addr,
    output logic [15:0] o_IO_data,
    output logic        o_hex_we,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);
    localparam logic [8:0] WIN_LO    = {1'b0, WINDOW_BASE};
    localparam logic [8:0] WIN_HI    = 9'({1'b0, WINDOW_BASE} + WINDOW_SIZE);

    state_t     state, state_d;
    logic       last;
    logic [3:0] hold_cnt;
    logic       win_vld;
    logic       win_idx;
    logic       xfer_done;
    logic       lock_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        win_vld   = 1'b0;
        win_idx   = 1'b0;
        xfer_done = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    win_vld = 1'b1;
                    state_d = GRANT;
                    if (i_req == 2'b11) win_idx = lock_pend ? last : ~last;
                    else                win_idx = i_req[1];
                end
            end
            GRANT: begin
                if (HOLD_CYCLES != 0) begin
                    state_d = HOLD;
                end else begin
                    state_d   = IDLE;
                    xfer_done = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == 4'd0) begin
                    state_d   = IDLE;
                    xfer_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant, ack and write strobe are single-cycle pulses; address/data persist until the next win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_gnt     <= 2'b00;
            o_ack     <= 2'b00;
            o_IO_we   <= 1'b0;
            o_IO_addr <= 8'h00;
            o_IO_data <= 16'h0000;
            last      <= 1'b1;
            hold_cnt  <= 4'd0;
        end else begin
            o_gnt   <= 2'b00;
            o_ack   <= 2'b00;
            o_IO_we <= 1'b0;
            if (win_vld) begin
                o_gnt     <= win_idx ? 2'b10 : 2'b01;
                o_ack     <= win_idx ? 2'b10 : 2'b01;
                o_IO_we   <= win_idx ? i_we1 : i_we0;
                o_IO_addr <= win_idx ? i_addr1 : i_addr0;
                o_IO_data <= win_idx ? i_data1 : i_data0;
                last      <= win_idx;
            end
            if (state == GRANT)
                hold_cnt <= HOLD_LOAD;
            else if (state == HOLD && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

`ifdef HEX_IO_ARB_LOCK_EN
    // Lock is judged when the transfer finishes and consumed by the next IDLE win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock_pend <= 1'b0;
        else if (xfer_done)
            lock_pend <= last ? (i_req[1] & i_lock[1]) : (i_req[0] & i_lock[0]);
        else if (win_vld)
            lock_pend <= 1'b0;
    end
`else
    assign lock_pend = 1'b0;
`endif

    assign o_busy   = (state != IDLE);
    assign o_hex_we = o_IO_we && ({1'b0, o_IO_addr} >= WIN_LO) && ({1'b0, o_IO_addr} < WIN_HI);

endmodule
